// File: rtl/mod_mult_pipe.sv
// Pipelined Barrett modular multiplier: res = (in1 * in2) mod Q, lock-step stall on back-pressure.
// Optional input reduction stage S0 enabled by defining MOD_MULT_INRED_EN.
module mod_mult_pipe #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329,
  parameter int BK    = 2*WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy
);

`ifdef MOD_MULT_INRED_EN
  localparam int STAGES = 4;
`else
  localparam int STAGES = 3;
`endif

  localparam logic [63:0]        BM_64 = (64'd1 << BK) / 64'(Q);
  localparam logic [4*WIDTH:0]   BM_W  = (4*WIDTH+1)'(BM_64);
  localparam logic [WIDTH-1:0]   Q_IN  = WIDTH'(Q);
  localparam logic [WIDTH+1:0]   Q_R   = (WIDTH+2)'(Q);
  localparam logic [2*WIDTH+1:0] Q_P   = (2*WIDTH+2)'(Q);

  logic                stall;
  logic [STAGES-1:0]   vld_pipe_q, vld_pipe_d;
  logic [WIDTH-1:0]    op_a, op_b;
  logic [2*WIDTH-1:0]  p1_q, p1_d, p2_q, p2_d;
  logic [WIDTH:0]      t2_q, t2_d;
  logic [WIDTH-1:0]    res_q, res_d;
  logic [4*WIDTH:0]    prod;
  logic [2*WIDTH+1:0]  tq;
  logic [WIDTH+1:0]    r_raw, r_fix;

  assign stall     = vld_pipe_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_pipe_q[STAGES-1];
  assign busy      = |vld_pipe_q;
  assign res       = res_q;

`ifdef MOD_MULT_INRED_EN
  logic [WIDTH-1:0] a0_q, a0_d, b0_q, b0_d;

  // Operands may span the full WIDTH range; one subtract suffices because 2*Q > 2^WIDTH.
  always_comb begin
    a0_d = a0_q;
    b0_d = b0_q;
    if (!stall) begin
      a0_d = (in1 >= Q_IN) ? in1 - Q_IN : in1;
      b0_d = (in2 >= Q_IN) ? in2 - Q_IN : in2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a0_q <= '0;
      b0_q <= '0;
    end else begin
      a0_q <= a0_d;
      b0_q <= b0_d;
    end
  end

  assign op_a = a0_q;
  assign op_b = b0_q;
`else
  assign op_a = in1;
  assign op_b = in2;
`endif

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    t2_d       = t2_q;
    res_d      = res_q;
    prod       = {{(2*WIDTH+1){1'b0}}, p1_q} * BM_W;
    tq         = {{(WIDTH+1){1'b0}}, t2_q} * Q_P;
    // Barrett quotient underestimates by at most one, so r_raw lies in [0, 2Q).
    r_raw      = (WIDTH+2)'({2'b00, p2_q} - tq);
    r_fix      = (r_raw >= Q_R) ? r_raw - Q_R : r_raw;
    if (!stall) begin
      vld_pipe_d = {vld_pipe_q[STAGES-2:0], in_valid};
      p1_d       = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
      t2_d       = (WIDTH+1)'(prod >> BK);
      p2_d       = p1_q;
      // res only moves on real data so it holds across empty slots.
      if (vld_pipe_q[STAGES-2])
        res_d = WIDTH'(r_fix);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      t2_q       <= '0;
      res_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      t2_q       <= t2_d;
      res_q      <= res_d;
    end
  end

endmodule

// File: doc/mod_mult_pipe.md
Name: mod_mult_pipe

Overview:
- Pipelined modular multiplier for the Kyber NTT datapath: res = (in1 * in2) mod Q.
- Barrett reduction, parametrised operand width and modulus.
- Valid/ready handshake on both sides with full-pipeline stall.
- Drop-in successor for the butterfly multiplier; sustains one product per clock when not back-pressured.

Parameters:
- WIDTH, 12, operand/result width in bits.
- Q, 3329, modulus. Required: Q < 2^WIDTH and 2*Q > 2^WIDTH.
- BK, 2*WIDTH, Barrett shift amount.
- BM, floor(2^BK / Q), Barrett constant (5039 for defaults). Computed in RTL from Q; never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- in1  in  WIDTH  operand A, range [0, Q-1] (see optional feature)
- in2  in  WIDTH  operand B, range [0, Q-1] (see optional feature)
- out_valid  out  1  res valid
- out_ready  in  1  downstream accepts res
- res  out  WIDTH  (in1*in2) mod Q, range [0, Q-1]
- busy  out  1  at least one stage holds valid data

Behaviour:
- Reset: rst sampled on the clk rising edge clears all stage valid bits and data registers. After reset: out_valid=0, res=0, busy=0, in_ready=1. Reset mid-operation discards all in-flight products; no output is produced for them.
- Transfer: an input transfers when in_valid && in_ready at a rising edge. An output transfers when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. While stall is 1:
  - every stage register holds, including its valid bit;
  - in_ready = 0.
  - Otherwise in_ready = 1. Bubbles are not compressed; the pipeline is lock-step.
- Pipeline, latency 3 cycles from input transfer to out_valid with no stall:
  - S1: p = in1*in2, width 2*WIDTH, registered with v1.
  - S2: t = (p*BM) >> BK, registered along with p and v2. Intermediate width is 4*WIDTH+1 bits before the shift.
  - S3: r = p - t*Q, width WIDTH+2. If r >= Q then r = r - Q. Registered to res with v3 = out_valid.
- Correctness: the Barrett error is at most one Q, so a single conditional subtract yields exact p mod Q for all legal inputs. The subtraction must never go negative; the bench asserts this.
- Output hold: res and out_valid remain stable while stalled.
- Empty slots: res holds its last value when out_valid drops. res is 0 only after reset.
- Throughput: 1 result/cycle when out_ready=1 continuously.
- busy = v1 | v2 | v3.
- Simultaneous events: an input accept and an output release in the same cycle are both honoured. in_valid with in_ready=0 is ignored; the source must hold the operands.
- Out-of-range operands (>= Q) with the optional feature disabled: the result is undefined but the handshake remains correct.

Optional Feature:
- Macro: MOD_MULT_INRED_EN.
- Defined:
  - Adds a stage S0 before S1. Each operand in [0, 2^WIDTH-1] is reduced by one conditional subtract (x >= Q ? x-Q : x).
  - Latency becomes 4. Stall rules extend to S0.
  - busy includes v0.
- Undefined:
  - No S0 stage; latency is 3.
  - Operands must already lie in [0, Q-1].

Test Plan:
- Reset release, no traffic -> out_valid=0, res=0, busy=0, in_ready=1 for 10 cycles.
- Single ops with out_ready=1: (10,300) -> 3000; (3300,3290) -> 1131; (3000,3111) -> 1813; (200,10) -> 2000; (3328,3328) -> 1. Each appears exactly 3 cycles after acceptance.
- Back-to-back stream of 4 ops, out_ready=1 -> 4 consecutive out_valid cycles in order. Then hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, res frozen, no loss or duplication after release.
- Assert rst for 1 cycle with 3 ops in flight -> all valids cleared next cycle; no stale result emerges afterward.
- Random sweep of 10k pairs in [0, 3328] with random out_ready -> every res matches the (a*b)%3329 reference model, in order.
- With MOD_MULT_INRED_EN: (4095,1) -> 766; (3329,5) -> 0; latency 4.
